// File: rtl/prbs31_pkg.sv
// PRBS31 shared definitions: polynomial x^31 + x^28 + 1 and checker states.
// Used by both the PRBS31 generator and the checker.
package prbs31_pkg;

   localparam int PRBS31_LEN   = 31;
   localparam int PRBS31_TAP_A = 28;
   localparam int PRBS31_TAP_B = 31;

   typedef enum logic {
      SEED  = 1'b0,
      CHECK = 1'b1
   } chk_state_e;

endpackage

// File: rtl/prbs31_lock_mon.sv
// PRBS31 lock monitor: counts errors over a window of checked beats.
// Ports: clk/rst_n (async, active-high), beat_i, err_i -> lose_lock_o.
module prbs31_lock_mon #(
   parameter int LOCK_WIN    = 64,
   parameter int LOCK_THRESH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic beat_i,
   input  logic err_i,
   output logic lose_lock_o
);

   localparam int CW = $clog2(LOCK_WIN);
   localparam int EW = $clog2(LOCK_WIN + 1);
   localparam int SW = EW + 1;
   localparam logic [SW-1:0] THR = SW'(LOCK_THRESH);
   localparam logic [CW-1:0] LAST = CW'(LOCK_WIN - 1);

   logic [CW-1:0] win_cnt_q, win_cnt_d;
   logic [EW-1:0] win_err_q, win_err_d;
   logic [SW-1:0] sum;

   // Error total including the beat being checked right now.
   assign sum = {1'b0, win_err_q} + {{EW{1'b0}}, err_i};
   assign lose_lock_o = beat_i && (sum >= THR);

   always_comb begin
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      if (beat_i) begin
         if (lose_lock_o || win_cnt_q == LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
         end else begin
            win_cnt_d = win_cnt_q + CW'(1);
            win_err_d = sum[EW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         win_cnt_q <= '0;
         win_err_q <= '0;
      end else begin
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
      end
   end

endmodule

// File: rtl/prbs31_checker.sv
// Serial PRBS31 checker: self-seeds, checks, counts errors, relocks.
// Ports: clk, rst_n (async, ACTIVE-HIGH), data_in, data_valid, clr ->
// locked, err_pulse, err_cnt, bit_cnt (only with PRBS31_CHK_BITCNT_EN).
module prbs31_checker
   import prbs31_pkg::*;
#(
   parameter int ERR_CNT_W   = 16,
   parameter int LOCK_WIN    = 64,
   parameter int LOCK_THRESH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 data_in,
   input  logic                 data_valid,
   input  logic                 clr,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PRBS31_CHK_BITCNT_EN
   ,
   output logic [31:0]          bit_cnt
`endif
);

   localparam logic [4:0] SEED_LAST = 5'(PRBS31_LEN - 1);

   chk_state_e                state_q, state_d;
   logic [PRBS31_LEN-1:0]     h_q, h_d;
   logic [4:0]                seed_cnt_q, seed_cnt_d;
   logic                      err_pulse_q;
   logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;
   logic                      pred, chk_beat, err, lose_lock;

   assign pred     = h_q[PRBS31_TAP_A-1] ^ h_q[PRBS31_TAP_B-1];
   assign chk_beat = data_valid && (state_q == CHECK);
   assign err      = chk_beat && (data_in ^ pred);

   prbs31_lock_mon #(
      .LOCK_WIN    (LOCK_WIN),
      .LOCK_THRESH (LOCK_THRESH)
   ) u_lock_mon (
      .clk         (clk),
      .rst_n       (rst_n),
      .beat_i      (chk_beat),
      .err_i       (err),
      .lose_lock_o (lose_lock)
   );

   always_comb begin
      state_d    = state_q;
      h_d        = h_q;
      seed_cnt_d = seed_cnt_q;
      if (data_valid) begin
         unique case (state_q)
            SEED: begin
               h_d = {h_q[PRBS31_LEN-2:0], data_in};
               if (seed_cnt_q == SEED_LAST) begin
                  seed_cnt_d = '0;
                  // All-zero history would lock up the predictor.
                  if (h_d != '0) state_d = CHECK;
               end else begin
                  seed_cnt_d = seed_cnt_q + 5'd1;
               end
            end
            CHECK: begin
               // Shift the prediction so one bad bit stays one error.
               h_d = {h_q[PRBS31_LEN-2:0], pred};
               if (lose_lock) begin
                  state_d    = SEED;
                  seed_cnt_d = '0;
               end
            end
            default: state_d = SEED;
         endcase
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clr) err_cnt_d = '0;
      else if (err && err_cnt_q != {ERR_CNT_W{1'b1}})
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= SEED;
         h_q         <= '0;
         seed_cnt_q  <= '0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         seed_cnt_q  <= seed_cnt_d;
         err_pulse_q <= err;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked    = (state_q == CHECK);
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;

`ifdef PRBS31_CHK_BITCNT_EN
   logic [31:0] bit_cnt_q, bit_cnt_d;

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (clr) bit_cnt_d = '0;
      else if (chk_beat) bit_cnt_d = bit_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) bit_cnt_q <= '0;
      else       bit_cnt_q <= bit_cnt_d;
   end

   assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: random and directed streams, scoreboarded
// against a bit-list reference of the PRBS31 checking rules.
module tb_prbs31_checker;

   localparam int W   = 4;
   localparam int WIN = 64;
   localparam int THR = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         data_in;
   logic         data_valid;
   logic         clr;
   logic         locked;
   logic         err_pulse;
   logic [W-1:0] err_cnt;
`ifdef PRBS31_CHK_BITCNT_EN
   logic [31:0]  bit_cnt;
`endif

   always #5 clk = ~clk;

   prbs31_checker #(
      .ERR_CNT_W   (W),
      .LOCK_WIN    (WIN),
      .LOCK_THRESH (THR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .clr        (clr),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_cnt    (err_cnt)
`ifdef PRBS31_CHK_BITCNT_EN
      ,
      .bit_cnt    (bit_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit     lk;
      bit     ep;
      int     ec;
      longint bc;
   } exp_t;

   exp_t sbq[$];

   // Reference model state
   bit     m_lk;
   bit     m_ep;
   int     m_ec;
   longint m_bc;
   bit     m_seed[$];
   bit     m_hist[$];
   int     m_wbeats;
   int     m_werrs;

   // Generator stream: o[n] = o[n-31] ^ o[n-28], first 31 bits 0..0,1
   bit     g[$];

   task automatic chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
      end
   endtask

   function automatic bit gen_bit();
      bit b;
      int n;
      n = g.size();
      if (n < 31) b = (n == 30);
      else b = g[n-31] ^ g[n-28];
      g.push_back(b);
      return b;
   endfunction

   function automatic void model_reset();
      m_lk = 0; m_ep = 0; m_ec = 0; m_bc = 0;
      m_seed.delete();
      m_hist.delete();
      m_wbeats = 0; m_werrs = 0;
   endfunction

   function automatic void model_beat(bit dv, bit din, bit c);
      bit p, e, any;
      m_ep = 0;
      if (dv && !m_lk) begin
         m_seed.push_back(din);
         if (m_seed.size() == 31) begin
            any = 0;
            foreach (m_seed[i]) any |= m_seed[i];
            if (any) begin
               m_lk = 1;
               m_hist = m_seed;
            end
            m_seed.delete();
         end
      end else if (dv) begin
         p = m_hist[m_hist.size()-28] ^ m_hist[m_hist.size()-31];
         e = din ^ p;
         m_hist.push_back(p);
         void'(m_hist.pop_front());
         m_bc = (m_bc + 1) & 64'hFFFF_FFFF;
         m_ep = e;
         if (e && m_ec < (1 << W) - 1) m_ec++;
         m_wbeats++;
         m_werrs += int'(e);
         if (m_werrs >= THR) begin
            m_lk = 0;
            m_wbeats = 0; m_werrs = 0;
         end else if (m_wbeats == WIN) begin
            m_wbeats = 0; m_werrs = 0;
         end
      end
      if (c) begin
         m_ec = 0;
         m_bc = 0;
      end
   endfunction

   function automatic void push_exp();
      exp_t x;
      x.lk = m_lk; x.ep = m_ep; x.ec = m_ec; x.bc = m_bc;
      sbq.push_back(x);
   endfunction

   // Called just after a posedge; returns just after the next one.
   task automatic step(bit dv, bit din, bit c);
      data_valid = dv;
      data_in    = din;
      clr        = c;
      model_beat(dv, din, c);
      push_exp();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      data_valid = 0;
      data_in    = 0;
      clr        = 0;
      rst_n      = 1;
      sbq.delete();
      model_reset();
      push_exp();
      #1;
      chk("rst_locked", longint'(locked), 0);
      chk("rst_err_pulse", longint'(err_pulse), 0);
      chk("rst_err_cnt", longint'(err_cnt), 0);
      @(posedge clk);
      #1;
      push_exp();
      rst_n = 0;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (sbq.size() > 0) begin
         x = sbq.pop_front();
         chk("locked", longint'(locked), longint'(x.lk));
         chk("err_pulse", longint'(err_pulse), longint'(x.ep));
         chk("err_cnt", longint'(err_cnt), longint'(x.ec));
`ifdef PRBS31_CHK_BITCNT_EN
         chk("bit_cnt", longint'(bit_cnt), x.bc);
`endif
      end
   end

   initial begin
      bit b;
      rst_n = 1; data_valid = 0; data_in = 0; clr = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Clean lock and 1000 beats
      g.delete();
      for (int i = 0; i < 30; i++) step(1, gen_bit(), 0);
      chk("no_lock_at_30", longint'(locked), 0);
      step(1, gen_bit(), 0);
      chk("lock_at_31", longint'(locked), 1);
      for (int i = 31; i < 1000; i++) step(1, gen_bit(), 0);
      chk("clean_err_cnt", longint'(err_cnt), 0);

      // Single inverted beat
      for (int i = 0; i < 200; i++) begin
         b = gen_bit();
         step(1, b ^ (i == 100), 0);
      end
      chk("single_err_cnt", longint'(err_cnt), 1);
      chk("single_locked", longint'(locked), 1);

      // Eight errors in one window -> loss of lock, then relock
      step(0, 0, 1);
      for (int i = 0; i < 50; i++) begin
         b = gen_bit();
         step(1, b ^ (i >= 10 && i <= 45 && i % 5 == 0), 0);
      end
      chk("burst_unlocked", longint'(locked), 0);
      chk("burst_err_cnt", longint'(err_cnt), 8);
      for (int i = 0; i < 100; i++) step(1, gen_bit(), 0);
      chk("relock", longint'(locked), 1);
      chk("relock_err_cnt", longint'(err_cnt), 8);

      // Constant zero never locks
      do_reset();
      for (int i = 0; i < 200; i++) step(1, 0, 0);
      chk("zero_locked", longint'(locked), 0);
      chk("zero_err_cnt", longint'(err_cnt), 0);

      // Toggling data_valid, clean stream
      do_reset();
      g.delete();
      for (int i = 0; i < 400; i++) begin
         if (i % 2 == 0) step(1, gen_bit(), 0);
         else step(0, 1'($urandom_range(0, 1)), 0);
      end
      chk("toggle_locked", longint'(locked), 1);
      chk("toggle_err_cnt", longint'(err_cnt), 0);

      // Random valid, errors and clears
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            b = gen_bit();
            step(1, b ^ ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 99) == 0);
         end else begin
            step(0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) == 0);
         end
      end

      // Saturation and clr priority
      do_reset();
      g.delete();
      for (int i = 0; i < 40; i++) step(1, gen_bit(), 0);
      for (int i = 0; i < 200; i++) begin
         b = gen_bit();
         step(1, b ^ (i % 10 == 5), 0);
      end
      chk("sat_err_cnt", longint'(err_cnt), 15);
      b = gen_bit();
      step(1, ~b, 1);
      chk("clr_prio_err_cnt", longint'(err_cnt), 0);
      chk("clr_prio_pulse", longint'(err_pulse), 1);

      // Reset mid-CHECK, then relock from scratch
      for (int i = 0; i < 20; i++) step(1, gen_bit(), 0);
      do_reset();
      g.delete();
      for (int i = 0; i < 30; i++) step(1, gen_bit(), 0);
      chk("rerst_no_lock", longint'(locked), 0);
      step(1, gen_bit(), 0);
      chk("rerst_lock", longint'(locked), 1);
      for (int i = 0; i < 20; i++) step(1, gen_bit(), 0);

      data_valid = 0;
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
